// File: rtl/pwm_multichannel_ramp.sv
// N-channel PWM generator with a shared period and prescaler. Each channel has
// a target duty and direction, and its active duty moves toward the target by
// at most RAMP_STEP once per frame. A direction reversal first ramps the duty
// to zero and only then flips the applied direction.
module pwm_multichannel_ramp #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned RAMP_STEP = 4,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic                wr_dir,
    output logic [CHANNELS-1:0] pwm,
    output logic [CHANNELS-1:0] dir,
    output logic [CHANNELS-1:0] settled,
    output logic                frame_start
);

    localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] STEP   = WIDTH'(RAMP_STEP);

    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             fs_q, fs_d;
    logic             tick, per_zero, wrap;

    logic [CHANNELS-1:0][WIDTH-1:0] tgt_q, tgt_d;
    logic [CHANNELS-1:0][WIDTH-1:0] act_q, act_d;
    logic [CHANNELS-1:0]            tgt_dir_q, tgt_dir_d;
    logic [CHANNELS-1:0]            dir_q, dir_d;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;

    // One ramp step from a toward t, clamped so it never overshoots.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] r;
        r = t;
        if (RAMP_STEP != 0) begin
            if (t > a) begin
                if ((t - a) > STEP) r = a + STEP;
            end else begin
                if ((a - t) > STEP) r = a - STEP;
            end
        end
        return r;
    endfunction

    // Effective compare threshold: a duty at or above the period means 100%.
    function automatic logic [WIDTH-1:0] min_w(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Prescaler, frame counter and period reload.
    always_comb begin
        pcnt_d   = pcnt_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tick     = enable && (pcnt_q == PCNT_MAX);
        per_zero = (period_q == '0);
        wrap     = tick && !per_zero && (cnt_q == period_q - WIDTH'(1));
        if (!enable) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PW'(1);
            if (tick) begin
                if (wrap || per_zero) begin
                    cnt_d    = '0;
                    period_d = period;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
        fs_d = wrap;
    end

    // Per-channel compare, frame-boundary ramp and target writes.
    always_comb begin
        tgt_d     = tgt_q;
        tgt_dir_d = tgt_dir_q;
        act_d     = act_q;
        dir_d     = dir_q;
        pwm_d     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < min_w(act_q[i], period_q));
            if (wrap) begin
                if (tgt_dir_q[i] != dir_q[i]) begin
                    if (act_q[i] != '0) act_d[i] = step_toward(act_q[i], '0);
                    else                dir_d[i] = tgt_dir_q[i];
                end else begin
                    act_d[i] = step_toward(act_q[i], tgt_q[i]);
                end
            end
            if (wr_en && (wr_ch == CH_W'(i))) begin
                tgt_d[i]     = wr_duty;
                tgt_dir_d[i] = wr_dir;
            end
        end
    end

    // Settled flag derived directly from the channel registers.
    always_comb begin
        settled = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            settled[i] = (act_q[i] == tgt_q[i]) && (dir_q[i] == tgt_dir_q[i]);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            fs_q      <= 1'b0;
            tgt_q     <= '0;
            tgt_dir_q <= '0;
            act_q     <= '0;
            dir_q     <= '0;
            pwm_q     <= '0;
        end else begin
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            fs_q      <= fs_d;
            tgt_q     <= tgt_d;
            tgt_dir_q <= tgt_dir_d;
            act_q     <= act_d;
            dir_q     <= dir_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm         = pwm_q;
    assign dir         = dir_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_pwm_multichannel_ramp.sv
// Bench for pwm_multichannel_ramp: two instances share stimulus, one with an
// immediate ramp and single-cycle ticks, one with RAMP_STEP=4 and PRESCALE=2.
module tb_pwm_multichannel_ramp;

    localparam int NCH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] period = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_duty = '0;
    logic       wr_dir = 1'b0;

    logic [NCH-1:0] pwm_a, dir_a, set_a, pwm_b, dir_b, set_b;
    logic           fs_a, fs_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    always #5 clk = ~clk;

    pwm_multichannel_ramp #(.CHANNELS(NCH), .WIDTH(8), .PRESCALE(1), .RAMP_STEP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .wr_dir(wr_dir),
        .pwm(pwm_a), .dir(dir_a), .settled(set_a), .frame_start(fs_a));

    pwm_multichannel_ramp #(.CHANNELS(NCH), .WIDTH(8), .PRESCALE(2), .RAMP_STEP(4)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .wr_dir(wr_dir),
        .pwm(pwm_b), .dir(dir_b), .settled(set_b), .frame_start(fs_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int PRE[2] = '{1, 2};
    int STP[2] = '{0, 4};
    int m_pre[2], m_pos[2], m_per[2];
    int m_tgt[2][NCH], m_act[2][NCH];
    bit m_tdir[2][NCH], m_dir[2][NCH], m_pwm[2][NCH];
    bit m_fs[2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pre[k] = 0; m_pos[k] = 0; m_per[k] = 0; m_fs[k] = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_tgt[k][c] = 0; m_act[k][c] = 0; m_tdir[k][c] = 0;
                    m_dir[k][c] = 0; m_pwm[k][c] = 0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin : mdl
                bit tk;
                bit wr;
                int a;
                bit d;
                tk = enable && (m_pre[k] == PRE[k] - 1);
                wr = tk && (m_per[k] != 0) && (m_pos[k] == m_per[k] - 1);
                for (int c = 0; c < NCH; c++)
                    m_pwm[k][c] = enable && (m_pos[k] < imin(m_act[k][c], m_per[k]));
                m_fs[k] = wr;
                if (wr) begin
                    for (int c = 0; c < NCH; c++) begin
                        a = m_act[k][c];
                        d = m_dir[k][c];
                        if (m_tdir[k][c] != d) begin
                            if (a != 0) a = (STP[k] == 0 || a <= STP[k]) ? 0 : a - STP[k];
                            else        d = m_tdir[k][c];
                        end else if (STP[k] == 0) begin
                            a = m_tgt[k][c];
                        end else if (m_tgt[k][c] > a) begin
                            a = (m_tgt[k][c] - a > STP[k]) ? a + STP[k] : m_tgt[k][c];
                        end else begin
                            a = (a - m_tgt[k][c] > STP[k]) ? a - STP[k] : m_tgt[k][c];
                        end
                        m_act[k][c] = a;
                        m_dir[k][c] = d;
                    end
                end
                if (!enable) begin
                    m_pre[k] = 0;
                    m_pos[k] = 0;
                end else begin
                    m_pre[k] = (m_pre[k] == PRE[k] - 1) ? 0 : m_pre[k] + 1;
                    if (tk) begin
                        if (wr || m_per[k] == 0) begin
                            m_pos[k] = 0;
                            m_per[k] = int'(period);
                        end else begin
                            m_pos[k] = m_pos[k] + 1;
                        end
                    end
                end
                if (wr_en && int'(wr_ch) < NCH) begin
                    m_tgt[k][int'(wr_ch)]  = int'(wr_duty);
                    m_tdir[k][int'(wr_ch)] = wr_dir;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                logic [NCH-1:0] e_pwm, e_dir, e_set;
                for (int c = 0; c < NCH; c++) begin
                    e_pwm[c] = m_pwm[k][c];
                    e_dir[c] = m_dir[k][c];
                    e_set[c] = (m_act[k][c] == m_tgt[k][c]) && (m_dir[k][c] == m_tdir[k][c]);
                end
                if (k == 0) begin
                    check("A.pwm", 32'(pwm_a), 32'(e_pwm));
                    check("A.dir", 32'(dir_a), 32'(e_dir));
                    check("A.settled", 32'(set_a), 32'(e_set));
                    check("A.frame_start", 32'(fs_a), 32'(m_fs[k]));
                end else begin
                    check("B.pwm", 32'(pwm_b), 32'(e_pwm));
                    check("B.dir", 32'(dir_b), 32'(e_dir));
                    check("B.settled", 32'(set_b), 32'(e_set));
                    check("B.frame_start", 32'(fs_b), 32'(m_fs[k]));
                end
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    function automatic bit fs_of(input int k);
        return (k == 0) ? fs_a : fs_b;
    endfunction

    function automatic bit pwm_of(input int k, input int ch);
        return (k == 0) ? pwm_a[ch] : pwm_b[ch];
    endfunction

    task automatic wr(input int ch, input int duty, input bit d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 8'(duty); wr_dir = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_fs(input int k);
        bit seen;
        seen = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            seen = fs_of(k);
        end
        check("wait_frame_start", 32'(seen), 32'd1);
    endtask

    // Counts high cycles from the next cycle up to and including the next frame_start.
    task automatic measure(input int k, input int ch, output int hi, output int len);
        bit seen;
        seen = 0; hi = 0; len = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            len++;
            if (pwm_of(k, ch)) hi++;
            seen = fs_of(k);
        end
        check("measure_bound", 32'(seen), 32'd1);
    endtask

    initial begin
        int hi, len, fcnt;
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, len, fcnt;
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        check("reset_pwm_a", 32'(pwm_a), 32'd0);
        check("reset_settled_a", 32'(set_a), 32'd7);
        check("reset_settled_b", 32'(set_b), 32'd7);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        period = 8'd100;

        // Immediate ramp: one frame at 20, then 70; frames are 100 cycles.
        wait_fs(0);
        wr(0, 20, 0);
        wait_fs(0);
        fork
            measure(0, 0, hi, len);
            wr(0, 70, 0);
        join
        check("t2_duty20", 32'(hi), 32'd20);
        check("t2_len", 32'(len), 32'd100);
        measure(0, 0, hi, len);
        check("t2_duty70", 32'(hi), 32'd70);
        check("t2_len2", 32'(len), 32'd100);

        // Slew-limited ramp 0 -> 4 -> 8 -> 10 at two clocks per tick.
        wait_fs(1);
        wr(1, 10, 0);
        wait_fs(1);
        check("t3_not_settled", 32'(set_b[1]), 32'd0);
        measure(1, 1, hi, len);
        check("t3_act4", 32'(hi), 32'd8);
        check("t3_len", 32'(len), 32'd200);
        check("t3_still_ramping", 32'(set_b[1]), 32'd0);
        measure(1, 1, hi, len);
        check("t3_act8", 32'(hi), 32'd16);
        check("t3_settled", 32'(set_b[1]), 32'd1);
        measure(1, 1, hi, len);
        check("t3_act10", 32'(hi), 32'd20);

        // Direction reversal: 8 -> 4 -> 0 -> flip -> 4 -> 8.
        wait_fs(1);
        wr(2, 8, 0);
        wait_fs(1);
        wait_fs(1);
        wr(2, 8, 1);
        wait_fs(1);
        measure(1, 2, hi, len);
        check("t4_down4", 32'(hi), 32'd8);
        check("t4_dir_held", 32'(dir_b[2]), 32'd0);
        measure(1, 2, hi, len);
        check("t4_zero_frame", 32'(hi), 32'd0);
        check("t4_dir_flipped", 32'(dir_b[2]), 32'd1);
        measure(1, 2, hi, len);
        check("t4_flip_frame_low", 32'(hi), 32'd0);
        measure(1, 2, hi, len);
        check("t4_up4", 32'(hi), 32'd8);
        check("t4_settled", 32'(set_b[2]), 32'd1);
        measure(1, 2, hi, len);
        check("t4_up8", 32'(hi), 32'd16);

        // Full duty gives constant high; period 0 gives constant low and no frames.
        wait_fs(0);
        wr(0, 255, 0);
        period = 8'd200;
        wait_fs(0);
        measure(0, 0, hi, len);
        check("t5_full_high", 32'(hi), 32'd200);
        check("t5_len200", 32'(len), 32'd200);
        period = 8'd0;
        wait_fs(0);
        hi = 0; fcnt = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (pwm_a[0]) hi++;
            if (fs_a) fcnt++;
        end
        check("t5_zero_low", 32'(hi), 32'd0);
        check("t5_no_frames", 32'(fcnt), 32'd0);

        // Write landing on the wrap tick is deferred one frame; bad channel ignored.
        period = 8'd100;
        wait_fs(0);
        repeat (99) @(posedge clk);
        #1;
        wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 8'd50; wr_dir = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("t6_on_wrap", 32'(fs_a), 32'd1);
        measure(0, 1, hi, len);
        check("t6_deferred", 32'(hi), 32'd10);
        measure(0, 1, hi, len);
        check("t6_applied", 32'(hi), 32'd50);
        fork
            measure(0, 1, hi, len);
            wr(3, 99, 1);
        join
        check("t6_oob_duty", 32'(hi), 32'd50);
        measure(0, 1, hi, len);
        check("t6_oob_duty2", 32'(hi), 32'd50);
        check("t6_oob_settled", 32'(set_a), 32'd7);

        // Disable: outputs low, writes still accepted, frame restarts on re-enable.
        @(posedge clk); #1;
        enable = 1'b0;
        wr(0, 30, 0);
        repeat (20) @(negedge clk);
        check("en0_pwm_a", 32'(pwm_a), 32'd0);
        check("en0_pwm_b", 32'(pwm_b), 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_fs(0);
        measure(0, 0, hi, len);
        check("en1_duty30", 32'(hi), 32'd30);

        // Asynchronous reset mid-frame while pwm is high.
        repeat (5) @(negedge clk);
        check("t1_pre_high", 32'(pwm_a[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_pwm_a", 32'(pwm_a), 32'd0);
        check("t1_dir_a", 32'(dir_a), 32'd0);
        check("t1_dir_b", 32'(dir_b), 32'd0);
        check("t1_fs", 32'(fs_a | fs_b), 32'd0);
        check("t1_settled_a", 32'(set_a), 32'd7);
        check("t1_settled_b", 32'(set_b), 32'd7);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
